// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file family.
//   - default geometry (DW_DEF, DEPTH_DEF, AW_DEF)
//   - clog2 helper used to derive address widths
//   - ZERO_REG/BYPASS defaults for the single-cycle and pipelined cores
package regfile_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned AW_DEF    = clog2(DEPTH_DEF);
  localparam int unsigned NR_DEF    = 3;
  localparam int unsigned NW_DEF    = 2;

  // Single-cycle core: r0 hardwired, forwarding on.
  localparam int unsigned SC_ZERO_REG   = 1;
  localparam int unsigned SC_BYPASS     = 1;
  // Pipelined core: r0 hardwired, forwarding on.
  localparam int unsigned PIPE_ZERO_REG = 1;
  localparam int unsigned PIPE_BYPASS   = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wen, waddr          : writeback ports; an enabled write clears busy
//   rsv_en, rsv_addr    : reservation; sets busy (wins over a same-cycle write)
//   busy                : current busy vector
//   busy_cnt            : registered popcount of busy
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned NW       = NW_DEF,
  parameter int unsigned ZERO_REG = SC_ZERO_REG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NW-1:0]    wen,
  input  logic [NW*AW-1:0] waddr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [DEPTH-1:0] busy,
  output logic [AW:0]      busy_cnt
);

  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;

  // Clears first, then the reservation, so a new producer issued in the
  // same cycle as the old one's writeback keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned j = 0; j < NW; j++) begin
      if (wen[j]) busy_nxt[waddr[j*AW +: AW]] = 1'b0;
    end
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register,
// write-to-read bypass and a busy scoreboard for pending writebacks.
//   clk, rst_n        : clock, asynchronous active-low reset
//   raddr/rdata/rbusy : NR combinational read ports (port k at slice k)
//   wen/waddr/wdata   : NW write ports, higher index wins on conflicts
//   rsv_en/rsv_addr   : mark a register as pending
//   busy_cnt          : registered number of busy registers
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned NR       = NR_DEF,
  parameter int unsigned NW       = NW_DEF,
  parameter int unsigned ZERO_REG = SC_ZERO_REG,
  parameter int unsigned BYPASS   = SC_BYPASS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  output logic [NR-1:0]    rbusy,
  input  logic [NW-1:0]    wen,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*DW-1:0] wdata,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [AW:0]      busy_cnt
);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;

  // Ports are visited in ascending order, so the last NBA (highest index)
  // takes effect on a same-address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned j = 0; j < NW; j++) begin
        if (wen[j] && !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0))) begin
          mem[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
        end
      end
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    always_comb begin
      ra = raddr[k*AW +: AW];
      rd = mem[ra];
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NW; j++) begin
          if (wen[j] && (waddr[j*AW +: AW] == ra)) rd = wdata[j*DW +: DW];
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
    end

    assign rdata[k*DW +: DW] = rd;
    assign rbusy[k]          = busy[ra];
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (wen),
    .waddr    (waddr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // A: defaults (ZERO_REG=1, BYPASS=1, NR=3, NW=2)
  logic [14:0] a_raddr;  logic [95:0] a_rdata; logic [2:0] a_rbusy;
  logic [1:0]  a_wen;    logic [9:0]  a_waddr; logic [63:0] a_wdata;
  logic        a_rsv_en; logic [4:0]  a_rsv_addr; logic [5:0] a_cnt;
  // B: ZERO_REG=0, BYPASS=0
  logic [14:0] b_raddr;  logic [95:0] b_rdata; logic [2:0] b_rbusy;
  logic [1:0]  b_wen;    logic [9:0]  b_waddr; logic [63:0] b_wdata;
  logic        b_rsv_en; logic [4:0]  b_rsv_addr; logic [5:0] b_cnt;
  // C: DW=16, DEPTH=8, NR=4, NW=1, ZERO_REG=0
  logic [11:0] c_raddr;  logic [63:0] c_rdata; logic [3:0] c_rbusy;
  logic [0:0]  c_wen;    logic [2:0]  c_waddr; logic [15:0] c_wdata;
  logic        c_rsv_en; logic [2:0]  c_rsv_addr; logic [3:0] c_cnt;

  regfile_mp u_a (
    .clk(clk), .rst_n(rst_n), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata), .rsv_en(a_rsv_en),
    .rsv_addr(a_rsv_addr), .busy_cnt(a_cnt)
  );

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .rsv_en(b_rsv_en),
    .rsv_addr(b_rsv_addr), .busy_cnt(b_cnt)
  );

  regfile_mp #(.DW(16), .DEPTH(8), .AW(3), .NR(4), .NW(1), .ZERO_REG(0), .BYPASS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .raddr(c_raddr), .rdata(c_rdata), .rbusy(c_rbusy),
    .wen(c_wen), .waddr(c_waddr), .wdata(c_wdata), .rsv_en(c_rsv_en),
    .rsv_addr(c_rsv_addr), .busy_cnt(c_cnt)
  );

  // Signal selectors for the scoreboard
  localparam int A_RD = 0, A_RB = 3, A_CNT = 6;
  localparam int B_RD = 10, B_RB = 13, B_CNT = 16;
  localparam int C_RD = 20, C_CNT = 26;

  typedef struct {
    string       nm;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [63:0] sample(input int s);
    if (s >= A_RD && s < A_RB)   return {32'h0, a_rdata[(s-A_RD)*32 +: 32]};
    if (s >= A_RB && s < A_CNT)  return {63'h0, a_rbusy[s-A_RB]};
    if (s == A_CNT)              return {58'h0, a_cnt};
    if (s >= B_RD && s < B_RB)   return {32'h0, b_rdata[(s-B_RD)*32 +: 32]};
    if (s >= B_RB && s < B_CNT)  return {63'h0, b_rbusy[s-B_RB]};
    if (s == B_CNT)              return {58'h0, b_cnt};
    if (s >= C_RD && s < C_RD+4) return {48'h0, c_rdata[(s-C_RD)*16 +: 16]};
    if (s == C_CNT)              return {60'h0, c_cnt};
    return 64'hx;
  endfunction

  task automatic push(input string nm, input int sel, input logic [63:0] e);
    exp_t x;
    x.nm = nm; x.sel = sel; x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic check_all();
    exp_t e;
    logic [63:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      act = sample(e.sel);
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", e.nm, act, e.exp);
      end
    end
  endtask

  task automatic idle_all();
    a_wen = '0; a_rsv_en = 1'b0;
    b_wen = '0; b_rsv_en = 1'b0;
    c_wen = '0; c_rsv_en = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  r0, r1, r2;
    logic [31:0] e0, e1, e2;   // same-cycle rdata
    logic [2:0]  eb;           // same-cycle rbusy
    logic [5:0]  ecnt;         // busy_cnt after the edge
  } vec_t;

  vec_t vt[11];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{2'b01, 5'd3, 5'd0, 32'h12345678, 32'h0, 1'b0, 5'd0, 5'd1, 5'd3, 5'd0,
               32'h0, 32'h12345678, 32'h0, 3'b000, 6'd0};
    vt[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4, 5'd0,
               32'h12345678, 32'h0, 32'h0, 3'b000, 6'd1};
    vt[2]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6, 5'd4, 5'd6, 5'd3,
               32'h0, 32'h0, 32'h12345678, 3'b001, 6'd2};
    vt[3]  = '{2'b10, 5'd0, 5'd4, 32'h0, 32'hCAFEF00D, 1'b0, 5'd0, 5'd4, 5'd6, 5'd9,
               32'hCAFEF00D, 32'h0, 32'h0, 3'b011, 6'd1};
    vt[4]  = '{2'b01, 5'd6, 5'd0, 32'h0BADC0DE, 32'h0, 1'b1, 5'd6, 5'd6, 5'd4, 5'd6,
               32'h0BADC0DE, 32'hCAFEF00D, 32'h0BADC0DE, 3'b101, 6'd1};
    vt[5]  = '{2'b11, 5'd9, 5'd9, 32'hAAAA0000, 32'h5555FFFF, 1'b0, 5'd0, 5'd9, 5'd6, 5'd9,
               32'h5555FFFF, 32'h0BADC0DE, 32'h5555FFFF, 3'b010, 6'd1};
    vt[6]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9, 5'd0,
               32'h0, 32'h5555FFFF, 32'h0, 3'b000, 6'd1};
    vt[7]  = '{2'b10, 5'd0, 5'd2, 32'h0, 32'h1, 1'b1, 5'd6, 5'd0, 5'd6, 5'd2,
               32'h0, 32'h0BADC0DE, 32'h1, 3'b010, 6'd1};
    vt[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd6,
               32'h5555FFFF, 32'h0, 32'h0BADC0DE, 3'b100, 6'd1};
    vt[9]  = '{2'b11, 5'd6, 5'd6, 32'h11111111, 32'h22222222, 1'b0, 5'd0, 5'd6, 5'd6, 5'd6,
               32'h22222222, 32'h22222222, 32'h22222222, 3'b111, 6'd0};
    vt[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd4, 5'd3,
               32'h22222222, 32'hCAFEF00D, 32'h12345678, 3'b000, 6'd0};

    idle_all();
    a_raddr = '0; a_waddr = '0; a_wdata = '0; a_rsv_addr = '0;
    b_raddr = '0; b_waddr = '0; b_wdata = '0; b_rsv_addr = '0;
    c_raddr = '0; c_waddr = '0; c_wdata = '0; c_rsv_addr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    a_raddr = {5'd31, 5'd5, 5'd1};
    #1;
    for (int k = 0; k < 3; k++) push($sformatf("rst_a_rd%0d", k), A_RD + k, 64'h0);
    push("rst_a_cnt", A_CNT, 64'h0);
    push("rst_b_cnt", B_CNT, 64'h0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors on A
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a_wen = vt[i].wen;
      a_waddr = {vt[i].wa1, vt[i].wa0};
      a_wdata = {vt[i].wd1, vt[i].wd0};
      a_rsv_en = vt[i].rsv;
      a_rsv_addr = vt[i].ra;
      a_raddr = {vt[i].r2, vt[i].r1, vt[i].r0};
      push($sformatf("v%0d_rd0", i), A_RD + 0, {32'h0, vt[i].e0});
      push($sformatf("v%0d_rd1", i), A_RD + 1, {32'h0, vt[i].e1});
      push($sformatf("v%0d_rd2", i), A_RD + 2, {32'h0, vt[i].e2});
      for (int k = 0; k < 3; k++) push($sformatf("v%0d_rb%0d", i, k), A_RB + k, {63'h0, vt[i].eb[k]});
      #1 check_all();
      push($sformatf("v%0d_cnt", i), A_CNT, {58'h0, vt[i].ecnt});
      @(posedge clk);
      #1 check_all();
    end
    @(negedge clk);
    idle_all();

    // B: no bypass, ordinary r0
    b_wen = 2'b01; b_waddr = {5'd0, 5'd3}; b_wdata = {32'h0, 32'h12345678};
    b_raddr = {5'd0, 5'd3, 5'd0};
    push("b_nobyp_same", B_RD + 1, 64'h0);
    #1 check_all();
    @(posedge clk);
    push("b_nobyp_next", B_RD + 1, 64'h12345678);
    #1 check_all();
    @(negedge clk);
    b_wen = 2'b11; b_waddr = {5'd9, 5'd9}; b_wdata = {32'h5555FFFF, 32'hAAAA0000};
    b_raddr = {5'd0, 5'd0, 5'd9};
    push("b_conf_same", B_RD + 0, 64'h0);
    #1 check_all();
    @(posedge clk);
    push("b_conf_next", B_RD + 0, 64'h5555FFFF);
    #1 check_all();
    @(negedge clk);
    b_wen = 2'b01; b_waddr = {5'd0, 5'd0}; b_wdata = {32'h0, 32'hFFFFFFFF};
    b_rsv_en = 1'b1; b_rsv_addr = 5'd0;
    b_raddr = {5'd0, 5'd0, 5'd0};
    push("b_r0_same", B_RD + 0, 64'h0);
    #1 check_all();
    @(posedge clk);
    push("b_r0_data", B_RD + 0, 64'hFFFFFFFF);
    push("b_r0_busy", B_RB + 0, 64'h1);
    push("b_r0_cnt", B_CNT, 64'h1);
    #1 check_all();
    @(negedge clk);
    idle_all();

    // C: parameter sweep, fill r[i] = i*0x1111
    for (int i = 0; i < 8; i++) begin
      c_wen = 1'b1; c_waddr = 3'(i); c_wdata = 16'(i * 16'h1111);
      @(negedge clk);
    end
    c_wen = 1'b0;
    for (int a = 0; a < 8; a++) begin
      c_raddr = {3'((a + 3) % 8), 3'((a + 2) % 8), 3'((a + 1) % 8), 3'(a)};
      for (int k = 0; k < 4; k++)
        push($sformatf("c_a%0d_p%0d", a, k), C_RD + k, 64'(((a + k) % 8) * 16'h1111));
      #1 check_all();
    end
    push("c_cnt", C_CNT, 64'h0);
    check_all();

    // Mid-run reset on A
    @(negedge clk);
    a_wen = 2'b01; a_waddr = {5'd0, 5'd5}; a_wdata = {32'h0, 32'hDEADBEEF};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
    a_raddr = {5'd0, 5'd7, 5'd5};
    @(posedge clk);
    push("mr_pre_rd", A_RD + 0, 64'hDEADBEEF);
    push("mr_pre_rb", A_RB + 1, 64'h1);
    push("mr_pre_cnt", A_CNT, 64'h1);
    #1 check_all();
    idle_all();
    #2 rst_n = 1'b0;
    push("mr_rd", A_RD + 0, 64'h0);
    push("mr_rb", A_RB + 1, 64'h0);
    push("mr_cnt", A_CNT, 64'h0);
    push("mr_b_cnt", B_CNT, 64'h0);
    #1 check_all();
    @(posedge clk);
    push("mr_hold_rd", A_RD + 0, 64'h0);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
